// File: rtl/add6_pkg.sv
// Shared definitions for the multi-precision add/sub sequencer: default geometry,
// operation encodings and controller state encoding.
package add6_pkg;

  localparam int unsigned ADD6_SLICE_W    = 6;
  localparam int unsigned ADD6_NUM_SLICES = 4;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_SUB    = 2'b01,
    OP_ACC    = 2'b10,
    OP_ACCSUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Subtracting ops add the inverted B with a carry-in of one.
  function automatic logic op_is_sub(input logic [1:0] op);
    return op[0];
  endfunction

  // Accumulating ops take the running accumulator in place of operand A.
  function automatic logic op_uses_acc(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/add6_slice.sv
// Combinational adder slice shared by all precision steps of the sequencer.
module add6_slice
  import add6_pkg::*;
#(
  parameter int unsigned SLICE_W = ADD6_SLICE_W
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  assign {cout, s} = (SLICE_W+1)'(a) + (SLICE_W+1)'(b) + (SLICE_W+1)'(cin);

endmodule

// File: rtl/add6_seq_ctrl.sv
// Multi-precision add/sub sequencer: runs one SLICE_W-bit slice per cycle through a
// shared adder, LSB first, rippling the carry through a register into a running accumulator.
module add6_seq_ctrl
  import add6_pkg::*;
#(
  parameter  int unsigned SLICE_W    = ADD6_SLICE_W,
  parameter  int unsigned NUM_SLICES = ADD6_NUM_SLICES,
  localparam int unsigned W          = SLICE_W * NUM_SLICES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         carry_out,
  output logic         overflow
);

  localparam int unsigned IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  typedef logic [NUM_SLICES-1:0][SLICE_W-1:0] slices_t;

  state_e           state;
  slices_t          a_q;
  slices_t          b_q;
  slices_t          acc;
  logic             carry_q;
  logic [IDX_W-1:0] idx;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;

  // Slice-select muxes feeding the shared adder.
  assign slice_a = a_q[idx];
  assign slice_b = b_q[idx];

  add6_slice #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  assign sum = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      carry_q   <= 1'b0;
      idx       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q      <= op_uses_acc(op) ? acc : slices_t'(a);
            b_q      <= op_is_sub(op) ? slices_t'(~b) : slices_t'(b);
            carry_q  <= op_is_sub(op);
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          acc[idx] <= slice_s;
          carry_q  <= slice_cout;
          idx      <= idx + IDX_W'(1);
          // Flags come from the MSB slice; A's sign bit is still in the latched copy.
          if (idx == LAST_IDX) begin
            idx       <= '0;
            carry_out <= slice_cout;
            overflow  <= (slice_a[SLICE_W-1] == slice_b[SLICE_W-1]) &&
                         (slice_s[SLICE_W-1] != slice_a[SLICE_W-1]);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add6_seq_ctrl.sv
// Bench for add6_seq_ctrl: directed vector table, handshake/reset sequences and
// random operations checked against an arithmetic reference model.
module tb_add6_seq_ctrl;
  import add6_pkg::*;

  localparam int unsigned W  = 24;
  localparam int unsigned NS = 4;
  localparam longint HALF = 64'sd8388608;
  localparam longint FULL = 64'sd16777216;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] acc_m;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  add6_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on the full-width operands.
  task automatic model_op(input logic [1:0] o, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          output logic [W-1:0] s, output logic co, output logic ov);
    longint ua, ub, ur, sa, sb, r;
    ua = longint'(o[1] ? acc_m : ai);
    ub = longint'(bi);
    sa = (ua >= HALF) ? ua - FULL : ua;
    sb = (ub >= HALF) ? ub - FULL : ub;
    if (o[0]) begin
      ur = ua - ub;
      co = (ua >= ub);
      r  = sa - sb;
    end else begin
      ur = ua + ub;
      co = (ur >= FULL);
      r  = sa + sb;
    end
    if (ur < 0) ur = ur + FULL;
    if (ur >= FULL) ur = ur - FULL;
    s  = W'(ur);
    ov = (r > HALF - 1) || (r < -HALF);
    acc_m = s;
  endtask

  // Drives a request from IDLE; returns one ns after the accepting edge.
  task automatic issue(input string tag, input logic [1:0] o, input logic [W-1:0] ai,
                       input logic [W-1:0] bi);
    check({tag, ".ready"}, 32'(in_ready), 32'd1);
    op = o; a = ai; b = bi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits the fixed latency (optionally jiggling inputs during RUN) and checks the result.
  task automatic wait_result(input string tag, input logic [W-1:0] es, input logic eco,
                             input logic eov, input bit noise);
    for (int c = 1; c <= NS; c++) begin
      if (noise && c < NS) begin
        in_valid = 1'b1; op = 2'($urandom); a = W'($urandom); b = W'($urandom);
      end
      @(posedge clk); #1;
      if (c == NS - 1) check({tag, ".early_valid"}, 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".sum"}, 32'(sum), 32'(es));
    check({tag, ".carry"}, 32'(carry_out), 32'(eco));
    check({tag, ".ovf"}, 32'(overflow), 32'(eov));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".rel_ready"}, 32'(in_ready), 32'd1);
    check({tag, ".rel_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ms;
    logic         mco, mov;
    logic [W-1:0] held;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    vecs[0] = '{OP_ADD,    24'h00003F, 24'h000001, 24'h000040, 1'b0, 1'b0};
    vecs[1] = '{OP_ADD,    24'hFFFFFF, 24'h000001, 24'h000000, 1'b1, 1'b0};
    vecs[2] = '{OP_ADD,    24'h7FFFFF, 24'h000001, 24'h800000, 1'b0, 1'b1};
    vecs[3] = '{OP_SUB,    24'h000000, 24'h000001, 24'hFFFFFF, 1'b0, 1'b0};
    vecs[4] = '{OP_SUB,    24'h800000, 24'h000001, 24'h7FFFFF, 1'b1, 1'b1};
    vecs[5] = '{OP_ADD,    24'h000010, 24'h000000, 24'h000010, 1'b0, 1'b0};
    vecs[6] = '{OP_ACC,    24'hABCDEF, 24'h000005, 24'h000015, 1'b0, 1'b0};
    vecs[7] = '{OP_ACCSUB, 24'h123456, 24'h000015, 24'h000000, 1'b1, 1'b0};
    vecs[8] = '{OP_SUB,    24'h000000, 24'h800000, 24'h800000, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = '0; b = '0;
    acc_m = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.sum", 32'(sum), 32'd0);
    check("rst.carry", 32'(carry_out), 32'd0);
    check("rst.ovf", 32'(overflow), 32'd0);

    for (int i = 0; i < 9; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      issue(tag, vecs[i].op, vecs[i].a, vecs[i].b);
      model_op(vecs[i].op, vecs[i].a, vecs[i].b, ms, mco, mov);
      wait_result(tag, vecs[i].s, vecs[i].co, vecs[i].ov, 1'b0);
      release_result(tag);
    end

    // Backpressure in DONE with in_valid pulses, then same-cycle handshake request.
    issue("bp", OP_ADD, 24'h012345, 24'h054321);
    model_op(OP_ADD, 24'h012345, 24'h054321, ms, mco, mov);
    wait_result("bp", 24'h066666, 1'b0, 1'b0, 1'b0);
    held = sum;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; op = OP_SUB; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      check("bp.valid", 32'(out_valid), 32'd1);
      check("bp.in_ready", 32'(in_ready), 32'd0);
      check("bp.sum", 32'(sum), 32'(held));
    end
    op = OP_SUB; a = 24'h000005; b = 24'h000007; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs.not_accepted", 32'(in_ready), 32'd1);
    check("hs.valid_low", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("hs.accepted", 32'(in_ready), 32'd0);
    model_op(OP_SUB, 24'h000005, 24'h000007, ms, mco, mov);
    wait_result("hs", 24'hFFFFFE, 1'b0, 1'b0, 1'b0);
    release_result("hs");

    // Reset while slice 2 of an ADD is about to run.
    issue("mrst", OP_ADD, 24'h123456, 24'h111111);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    acc_m = '0;
    check("mrst.in_ready", 32'(in_ready), 32'd1);
    check("mrst.out_valid", 32'(out_valid), 32'd0);
    check("mrst.sum", 32'(sum), 32'd0);
    issue("mrst_acc", OP_ACC, 24'hFFFFFF, 24'h000003);
    model_op(OP_ACC, 24'hFFFFFF, 24'h000003, ms, mco, mov);
    wait_result("mrst_acc", 24'h000003, 1'b0, 1'b0, 1'b0);
    release_result("mrst_acc");

    // Random operations, with input noise during RUN on odd iterations.
    for (int i = 0; i < 40; i++) begin
      string tag;
      tag = $sformatf("rnd%0d", i);
      ro = 2'($urandom);
      ra = W'($urandom);
      rb = (i % 5 == 0) ? W'(1 << 23) : W'($urandom);
      issue(tag, ro, ra, rb);
      model_op(ro, ra, rb, ms, mco, mov);
      wait_result(tag, ms, mco, mov, bit'(i % 2));
      if (i % 7 == 3) begin
        held = sum;
        repeat (2) @(posedge clk);
        #1;
        check({tag, ".hold"}, 32'(sum), 32'(held));
      end
      release_result(tag);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
